hex_display_reader: RTL

Decodes the five active-low seven-segment digit buses (HEX4..HEX0) of the top-level display path back into a numeric value. It is the decoder counterpart of the display encoder. It waits for the display pattern to settle, validates the digit layout, and converts the digits serially into a binary magnitude and a sign. It emits a one-cycle valid pulse per new stable reading. It sits beside the display outputs as a self-check and readback monitor.

---
 rtl/hex_display_reader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/hex_display_reader.sv
// hex_display_reader: reads the five active-low seven-segment digit buses
// back into a signed decimal value. A pattern must hold still for
// STABLE_CYCLES samples, is checked for a legal digit layout, and is then
// converted serially, most significant digit first.
//
// Output handshake: valid is a single-cycle strobe with no back-pressure.
// value/negative/bcd change only in the cycle valid is high and hold their
// contents otherwise. error is a level that clears only together with valid.
module hex_display_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  HEX4,
  input  logic [6:0]  HEX3,
  input  logic [6:0]  HEX2,
  input  logic [6:0]  HEX1,
  input  logic [6:0]  HEX0,
  output logic [16:0] value,
  output logic        negative,
  output logic        valid,
  output logic        error,
  output logic [19:0] bcd,
  output logic [1:0]  dbg_state
);

  // Internal digit classes; 0..9 are the digit values themselves.
  localparam logic [3:0] C_BLANK = 4'hA;
  localparam logic [3:0] C_MINUS = 4'hB;
  localparam logic [3:0] C_BAD   = 4'hE;

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_CONVERT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   return 4'd0;
      7'h79:   return 4'd1;
      7'h24:   return 4'd2;
      7'h30:   return 4'd3;
      7'h19:   return 4'd4;
      7'h12:   return 4'd5;
      7'h02:   return 4'd6;
      7'h78:   return 4'd7;
      7'h00:   return 4'd8;
      7'h10:   return 4'd9;
      7'h7F:   return C_BLANK;
      7'h3F:   return C_MINUS;
      default: return C_BAD;
    endcase
  endfunction

  state_t      state, state_next;
  logic [34:0] hex_in, hex_q, last_rep;
  logic        reported;
  logic [7:0]  stab_cnt;
  logic [16:0] acc, acc_next;
  logic [2:0]  idx;
  logic [3:0]  dig [5];
  logic [3:0]  cur_code, cur_val;
  logic [19:0] bcd_next;
  logic        changed, stable_hit, is_repeat;
  logic        legal, leading, minus_seen;
  logic        start_conv, set_err, step, finish;

  assign hex_in     = {HEX4, HEX3, HEX2, HEX1, HEX0};
  assign changed    = (hex_in != hex_q);
  assign stable_hit = !changed && (stab_cnt == 8'(STABLE_CYCLES - 1));
  assign is_repeat  = reported && (hex_q == last_rep);
  assign dbg_state  = state;

  // Classify each held digit, check the layout and build the bcd image.
  always_comb begin
    legal      = 1'b1;
    leading    = 1'b1;
    minus_seen = 1'b0;
    bcd_next   = '0;
    for (int i = 0; i < 5; i++) begin
      dig[i] = seg_decode(hex_q[7*i +: 7]);
      bcd_next[4*i +: 4] = (dig[i] <= 4'd9) ? dig[i] : 4'hF;
    end
    // Scan from HEX4 down: blanks only while leading, one minus right after.
    for (int i = 4; i >= 0; i--) begin
      if (dig[i] == C_BLANK) begin
        if (!leading) legal = 1'b0;
      end else if (dig[i] == C_MINUS) begin
        if (!leading || i == 0) legal = 1'b0;
        leading    = 1'b0;
        minus_seen = 1'b1;
      end else if (dig[i] <= 4'd9) begin
        leading = 1'b0;
      end else begin
        legal = 1'b0;
      end
    end
  end

  // Select the digit for the current conversion step; blank/minus count as 0.
  always_comb begin
    case (idx)
      3'd4:    cur_code = dig[4];
      3'd3:    cur_code = dig[3];
      3'd2:    cur_code = dig[2];
      3'd1:    cur_code = dig[1];
      default: cur_code = dig[0];
    endcase
    cur_val  = (cur_code <= 4'd9) ? cur_code : 4'd0;
    acc_next = acc * 17'd10 + {13'd0, cur_val};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_WAIT: begin
        if (stable_hit) state_next = (legal && !is_repeat) ? S_CONVERT : S_HOLD;
      end
      S_CONVERT: begin
        if (changed)        state_next = S_WAIT;
        else if (idx == '0) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (changed) state_next = S_WAIT;
      end
      default: state_next = S_WAIT;
    endcase
  end

  // Control strobes decoded from the state.
  always_comb begin
    start_conv = 1'b0;
    set_err    = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      S_WAIT: begin
        if (stable_hit && !is_repeat) begin
          if (legal) start_conv = 1'b1;
          else       set_err    = 1'b1;
        end
      end
      S_CONVERT: begin
        if (!changed) begin
          step   = 1'b1;
          finish = (idx == '0);
        end
      end
      default: ;
    endcase
  end

  // Sampler, serial accumulator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q    <= {5{7'h7F}};
      stab_cnt <= '0;
      acc      <= '0;
      idx      <= '0;
      last_rep <= '0;
      reported <= 1'b0;
      value    <= '0;
      negative <= 1'b0;
      valid    <= 1'b0;
      error    <= 1'b0;
      bcd      <= 20'hFFFFF;
    end else begin
      valid <= 1'b0;
      if (changed) begin
        hex_q    <= hex_in;
        stab_cnt <= '0;
      end else if (stab_cnt != 8'hFF) begin
        stab_cnt <= stab_cnt + 8'd1;
      end
      if (start_conv) begin
        acc <= '0;
        idx <= 3'd4;
      end
      if (set_err) error <= 1'b1;
      if (step) begin
        acc <= acc_next;
        idx <= idx - 3'd1;
      end
      if (finish) begin
        value    <= acc_next;
        negative <= minus_seen && (acc_next != '0);
        bcd      <= bcd_next;
        last_rep <= hex_q;
        reported <= 1'b1;
        error    <= 1'b0;
        valid    <= 1'b1;
      end
    end
  end

endmodule
